// File: rtl/router_pkg.sv
// Shared router types: tile transaction format and arbiter credit depth.
package router_pkg;

    localparam int ARB_CREDITS = 4;

    typedef struct packed {
        logic [7:0]  src;
        logic [23:0] payload;
    } t_tile_trans;

endpackage

// File: rtl/rr_pick.sv
// Combinational find-first-set starting at ptr, wrapping modulo NUM_CLIENTS.
module rr_pick #(
    parameter  int NUM_CLIENTS = 4,
    localparam int IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_CLIENTS-1:0] gnt,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic                   any
);

    logic [NUM_CLIENTS-1:0]   hi_mask;
    logic [2*NUM_CLIENTS-1:0] dbl;
    logic                     found;

    // Low half holds requests at or above ptr, high half the full vector,
    // so a single LSB-first scan yields the wrapped search order.
    always_comb begin
        hi_mask = {NUM_CLIENTS{1'b1}} << ptr;
        dbl     = {req, req & hi_mask};
        any     = |req;
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < 2*NUM_CLIENTS; i++) begin
            if (!found && dbl[i]) begin
                found   = 1'b1;
                gnt_idx = IDX_W'(i % NUM_CLIENTS);
            end
        end
        gnt = any ? (NUM_CLIENTS'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/rr_credit_arb.sv
// Credit-gated round-robin arbiter driving one registered tile output link.
module rr_credit_arb
    import router_pkg::*;
#(
    parameter  int NUM_CLIENTS = 4,
    parameter  int CREDITS     = ARB_CREDITS,
    localparam int CREDIT_W    = $clog2(CREDITS+1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic        [NUM_CLIENTS-1:0]       valid_candidate,
    input  t_tile_trans [NUM_CLIENTS-1:0]       candidate,
    output logic        [NUM_CLIENTS-1:0]       fifo_pop,
    output logic                                winner_req_valid,
    output t_tile_trans                         winner_req,
    input  logic                                credit_return,
    output logic        [CREDIT_W-1:0]          credit_cnt,
    output logic                                credit_ovf
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);
    localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(CREDITS);

    logic [IDX_W-1:0]       rr_ptr;
    logic [NUM_CLIENTS-1:0] gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   any;
    logic                   send;

    rr_pick #(.NUM_CLIENTS(NUM_CLIENTS)) u_pick (
        .req     (valid_candidate),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Credit check uses the registered count only: no path from credit_return.
    assign send     = any && (credit_cnt != '0);
    assign fifo_pop = (send && !rst) ? gnt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr           <= '0;
            winner_req_valid <= 1'b0;
            winner_req       <= '0;
        end else begin
            winner_req_valid <= send;
            if (send) begin
                winner_req <= candidate[gnt_idx];
                rr_ptr     <= (gnt_idx == IDX_W'(NUM_CLIENTS-1)) ? '0 : gnt_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_cnt <= CRED_MAX;
            credit_ovf <= 1'b0;
        end else begin
            case ({send, credit_return})
                2'b10: credit_cnt <= credit_cnt - CREDIT_W'(1);
                2'b01: begin
                    if (credit_cnt == CRED_MAX) credit_ovf <= 1'b1;
                    else                        credit_cnt <= credit_cnt + CREDIT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rr_credit_arb.md
# rr_credit_arb

Credit-gated round-robin arbiter that shares one router output link among NUM_CLIENTS input FIFOs. Each cycle it selects one non-empty FIFO, pops it, and forwards the head transaction to the next tile on a registered output. A transaction is sent only when the downstream FIFO is known to have room, which is tracked with a credit counter. It sits between the per-direction input FIFOs and the outgoing tile link, and replaces a free-running arbiter that ignores downstream readiness.

## Interface
- NUM_CLIENTS, 4: number of requesting FIFOs; must be at least 2.
- CREDITS, 4: downstream FIFO depth, which is the initial and maximum credit count.
- CREDIT_W, $clog2(CREDITS+1): width of the credit counter (derived, not overridden).
- clk  in  1  Single clock.
- rst  in  1  Reset; asynchronous, active-high.
- valid_candidate  in  NUM_CLIENTS  Not-empty flag of each input FIFO.
- candidate  in  t_tile_trans[NUM_CLIENTS]  Head data of each input FIFO (show-ahead).
- fifo_pop  out  NUM_CLIENTS  One-hot, or zero when idle. Pops the winning FIFO in the same cycle.
- winner_req_valid  out  1  Registered; high for one cycle per forwarded transaction.
- winner_req  out  t_tile_trans  Registered; the forwarded transaction.
- credit_return  in  1  One-cycle pulse from downstream each time it pops its FIFO.
- credit_cnt  out  CREDIT_W  Current credits, for debug.
- credit_ovf  out  1  Sticky error flag: a credit was returned while the counter was already at CREDITS.

## Operation
- Grant condition: any valid_candidate bit is set AND credit_cnt != 0.
- Round-robin selection:
  - The search starts at rr_ptr and wraps modulo NUM_CLIENTS.
  - The winner w is the first valid index found.
  - On a grant, rr_ptr <= (w+1) mod NUM_CLIENTS, so w == NUM_CLIENTS-1 wraps to 0.
  - With no grant, rr_ptr holds.
- On a grant in cycle t:
  - fifo_pop[w]=1 in cycle t.
  - winner_req <= candidate[w].
  - winner_req_valid <= 1, visible at t+1.
- With no grant, winner_req_valid <= 0 and winner_req holds its last value.
- Credit update per cycle, with send = grant:
  - send only: credit_cnt-1.
  - credit_return only: credit_cnt+1.
  - Both in the same cycle: unchanged.
  - Neither: unchanged.
- Credit overflow: credit_return with credit_cnt==CREDITS and no send leaves the count at CREDITS and sets credit_ovf. The flag clears only on rst.
- Credits reaching 0: fifo_pop stays all-zero until a credit_return arrives. A credit returned in cycle t allows a grant in cycle t+1, not in cycle t (the credit check uses the registered credit_cnt).
- Downstream must accept every winner_req_valid pulse. There is no ready signal on the output; the credit scheme guarantees space.

## Timing
- Reset values: rr_ptr=0, credit_cnt=CREDITS, credit_ovf=0, winner_req_valid=0, winner_req='0.
- fifo_pop is forced to 0 while rst is high.
- Latency from fifo_pop to winner_req_valid is 1 cycle.
- Throughput is one transaction per cycle while credits remain.
- fifo_pop is combinational from valid_candidate, rr_ptr and credit_cnt. There is no combinational path from credit_return to fifo_pop.
- Reset asserted mid-stream: all state returns to reset values immediately. Any transaction popped in the cycle rst rises is dropped. Upstream and downstream FIFOs are reset by the same rst.
- A single-client case (one valid bit) is granted every cycle while credits last, regardless of rr_ptr.

## Structure
- router_pkg provides t_tile_trans and the constant ARB_CREDITS, used as the default for CREDITS.
- Sub-module rr_pick: a purely combinational find-first-from-pointer.
  - Inputs: req[NUM_CLIENTS], ptr.
  - Outputs: gnt one-hot, gnt_idx, any.
  - Implemented by double-width masking of req; it is reused by other router arbiters.
- The top level holds rr_ptr, the credit counter, the overflow flag and the output registers.

## Test plan
- Reset release with all four clients valid and no credit_return: pops go 0,1,2,3 in consecutive cycles, then stop; credit_cnt=0; winner_req_valid pulses for 4 cycles, each one cycle after its pop.
- Credits at 0, clients 1 and 3 valid, credit_return pulsed at cycle t: the next pop is at t+1 and selects client 1 (rr_ptr=0); credit_cnt returns to 0.
- credit_cnt=2 with continuous credit_return and client 2 always valid: a pop every cycle, credit_cnt stays 2, winner_req equals the head of client 2 one cycle later.
- credit_return at credit_cnt=4 with no requests: credit_cnt stays 4 and credit_ovf=1 until rst.
- Wrap: rr_ptr=3, clients 0 and 3 valid → grant 3, then 0, and rr_ptr becomes 1.
- rst asserted mid-burst with credit_cnt=1: all outputs return to reset values in the same cycle, and credit_cnt reads 4 after release.
